// File: rtl/i2c_pkg.sv
// Shared I2C definitions: responder FSM state encoding and default device address.
package i2c_pkg;

  localparam logic [6:0] DefDevAddr = 7'h4C;

  typedef enum logic [3:0] {
    StIdle,
    StDevAddr,
    StDevAck,
    StSubAddr,
    StSubAck,
    StWrData,
    StWrAck,
    StRdData,
    StRdAck
  } i2c_state_e;

endpackage

// File: rtl/i2c_bus_sync.sv
// Two-flop synchronizers for scl/sda plus edge, START and STOP detection.
module i2c_bus_sync (
  input  logic clk,
  input  logic reset,
  input  logic scl,
  input  logic sda,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  // [1:0] form the synchronizer, [2] is the previous synchronized value for edges
  logic [2:0] scl_q;
  logic [2:0] sda_q;

  // Shift pad values through the synchronizer chains; idle bus level is high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_q <= 3'b111;
      sda_q <= 3'b111;
    end else begin
      scl_q <= {scl_q[1:0], scl};
      sda_q <= {sda_q[1:0], sda};
    end
  end

  assign sda_s     = sda_q[1];
  assign scl_rise  = scl_q[1] & ~scl_q[2];
  assign scl_fall  = ~scl_q[1] & scl_q[2];
  // sda may only move while scl is low, so an sda edge with scl high is START/STOP
  assign start_det = scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
  assign stop_det  = scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];

endmodule

// File: rtl/i2c_reg_responder.sv
// I2C target exposing a byte-wide register file with an auto-incrementing pointer.
module i2c_reg_responder
  import i2c_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR = DefDevAddr,
  parameter int unsigned REG_AW   = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              scl,
  inout  wire               sda,
  output logic              wr_stb,
  output logic [REG_AW-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy
);

  localparam int unsigned Depth = 2 ** REG_AW;

  logic sda_s, scl_rise, scl_fall, start_det, stop_det;

  i2c_bus_sync u_sync (
    .clk       (clk),
    .reset     (reset),
    .scl       (scl),
    .sda       (sda),
    .sda_s     (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  i2c_state_e        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic [REG_AW-1:0] ptr_q, ptr_d, ptr_inc;
  logic              oe_q, oe_d;
  logic              busy_q, busy_d;
  logic              wr_stb_q, wr_stb_d;
  logic [REG_AW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic [7:0]        sampled;
  logic              reg_we;
  logic [7:0]        regs_q [Depth];

  // Open drain: only ever pull low or float
  assign sda     = oe_q ? 1'b0 : 1'bz;
  assign wr_stb  = wr_stb_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = busy_q;

  assign ptr_inc = ptr_q + 1'b1;
  assign sampled = {shift_q[6:0], sda_s};

  // Next-state logic: START/STOP override everything, otherwise bit-level sequencing.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    oe_d      = oe_q;
    busy_d    = busy_q;
    wr_stb_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    reg_we    = 1'b0;

    if (stop_det) begin
      state_d = StIdle;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
      cnt_d   = 4'd0;
    end else if (start_det) begin
      state_d = StDevAddr;
      oe_d    = 1'b0;
      cnt_d   = 4'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          oe_d = 1'b0;
        end

        StDevAddr, StSubAddr, StWrData: begin
          if (scl_rise) begin
            shift_d = sampled;
            cnt_d   = cnt_q + 4'd1;
            // Commit only on a full byte so a STOP mid-byte leaves no trace
            if (state_q == StWrData && cnt_q == 4'd7) begin
              reg_we    = 1'b1;
              wr_stb_d  = 1'b1;
              wr_addr_d = ptr_q;
              wr_data_d = sampled;
              ptr_d     = ptr_inc;
            end
          end else if (scl_fall && cnt_q == 4'd8) begin
            cnt_d = 4'd0;
            if (state_q == StDevAddr) begin
              if (shift_q[7:1] == DEV_ADDR) begin
                state_d = StDevAck;
                oe_d    = 1'b1;
                busy_d  = 1'b1;
              end else begin
                state_d = StIdle;
                busy_d  = 1'b0;
              end
            end else if (state_q == StSubAddr) begin
              ptr_d   = shift_q[REG_AW-1:0];
              state_d = StSubAck;
              oe_d    = 1'b1;
            end else begin
              state_d = StWrAck;
              oe_d    = 1'b1;
            end
          end
        end

        StDevAck: begin
          if (scl_fall) begin
            cnt_d = 4'd0;
            if (shift_q[0]) begin
              state_d = StRdData;
              shift_d = regs_q[ptr_q];
              oe_d    = ~regs_q[ptr_q][7];
            end else begin
              state_d = StSubAddr;
              oe_d    = 1'b0;
            end
          end
        end

        StSubAck, StWrAck: begin
          if (scl_fall) begin
            state_d = StWrData;
            oe_d    = 1'b0;
            cnt_d   = 4'd0;
          end
        end

        StRdData: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              state_d = StRdAck;
              oe_d    = 1'b0;
              cnt_d   = 4'd0;
            end else begin
              // cnt counts bits already clocked out, so it selects the next MSB-first bit
              oe_d = ~shift_q[3'd7 - cnt_q[2:0]];
            end
          end
        end

        StRdAck: begin
          if (scl_rise) begin
            if (sda_s) begin
              state_d = StIdle;
              oe_d    = 1'b0;
            end else begin
              // Preload next byte now; its MSB is driven on the coming scl fall
              state_d = StRdData;
              ptr_d   = ptr_inc;
              shift_d = regs_q[ptr_inc];
              cnt_d   = 4'd0;
            end
          end
        end

        default: begin
          state_d = StIdle;
          oe_d    = 1'b0;
        end
      endcase
    end
  end

  // Control and output state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      shift_q   <= 8'h00;
      ptr_q     <= '0;
      oe_q      <= 1'b0;
      busy_q    <= 1'b0;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      ptr_q     <= ptr_d;
      oe_q      <= oe_d;
      busy_q    <= busy_d;
      wr_stb_q  <= wr_stb_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // Register file: cleared by reset, written once per completed data byte.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        regs_q[i] <= 8'h00;
      end
    end else if (reg_we) begin
      regs_q[ptr_q] <= sampled;
    end
  end

endmodule

// File: tb/tb_i2c_reg_responder.sv
// Scoreboard bench: open-drain I2C master tasks drive the responder; expected
// write strobes and bus bytes/ACKs are queued and checked by a monitor process.
`timescale 1ns/1ps
module tb_i2c_reg_responder;

  localparam int unsigned RegAw = 6;
  // Quarter scl period; master runs faster than 100 kHz to keep the run short
  localparam int Q = 250;

  logic              clk = 1'b0;
  logic              reset;
  logic              scl_drv;
  logic              sda_drv;
  wire               scl;
  wire               sda;
  logic              wr_stb;
  logic [RegAw-1:0]  wr_addr;
  logic [7:0]        wr_data;
  logic              busy;

  int n_checks = 0;
  int n_fail   = 0;

  int unsigned wr_exp_addr_q[$];
  logic [7:0]  wr_exp_data_q[$];
  string       bus_name_q[$];
  logic [7:0]  bus_exp_q[$];
  logic [7:0]  bus_obs_q[$];

  assign scl = scl_drv ? 1'bz : 1'b0;
  assign sda = sda_drv ? 1'bz : 1'b0;
  pullup (scl);
  pullup (sda);

  always #5 clk = ~clk;

  i2c_reg_responder #(
    .DEV_ADDR (7'h4C),
    .REG_AW   (RegAw)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .scl     (scl),
    .sda     (sda),
    .wr_stb  (wr_stb),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .busy    (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_wr(input int unsigned a, input logic [7:0] d);
    wr_exp_addr_q.push_back(a);
    wr_exp_data_q.push_back(d);
  endtask

  task automatic expect_bus(input string name, input logic [7:0] v);
    bus_name_q.push_back(name);
    bus_exp_q.push_back(v);
  endtask

  task automatic i2c_start();
    sda_drv = 1'b1; #(Q);
    scl_drv = 1'b1; #(Q);
    sda_drv = 1'b0; #(Q);
    scl_drv = 1'b0; #(Q);
  endtask

  task automatic i2c_stop();
    sda_drv = 1'b0; #(Q);
    scl_drv = 1'b1; #(Q);
    sda_drv = 1'b1; #(Q);
  endtask

  task automatic put_bit(input logic b);
    sda_drv = b;    #(Q);
    scl_drv = 1'b1; #(2 * Q);
    scl_drv = 1'b0; #(Q);
  endtask

  task automatic get_bit(output logic b);
    sda_drv = 1'b1; #(Q);
    scl_drv = 1'b1; #(Q);
    b = sda;        #(Q);
    scl_drv = 1'b0; #(Q);
  endtask

  // Send a byte and queue the ACK bit seen on the 9th clock (0 = ACK)
  task automatic send_byte(input string name, input logic [7:0] b, input logic exp_ack);
    logic a;
    expect_bus(name, {7'd0, exp_ack});
    for (int i = 7; i >= 0; i--) put_bit(b[i]);
    get_bit(a);
    bus_obs_q.push_back({7'd0, a});
  endtask

  task automatic recv_byte(input string name, input logic [7:0] exp, input logic ack);
    logic [7:0] v;
    logic       bv;
    expect_bus(name, exp);
    for (int i = 7; i >= 0; i--) begin
      get_bit(bv);
      v[i] = bv;
    end
    bus_obs_q.push_back(v);
    put_bit(ack);
  endtask

  // Monitor: compare every write strobe and every observed bus value against the queues
  always @(negedge clk) begin
    if (wr_stb === 1'b1) begin
      if (wr_exp_addr_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected wr_stb: addr %0d data 0x%0h, none expected", wr_addr, wr_data);
      end else begin
        check("wr_addr", 32'(wr_addr), 32'(wr_exp_addr_q.pop_front()));
        check("wr_data", 32'(wr_data), 32'(wr_exp_data_q.pop_front()));
      end
    end
    while (bus_obs_q.size() > 0) begin
      if (bus_exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected bus value: got 0x%0h, none expected", bus_obs_q.pop_front());
      end else begin
        check(bus_name_q.pop_front(), 32'(bus_obs_q.pop_front()), 32'(bus_exp_q.pop_front()));
      end
    end
  end

  initial begin
    #(5_000_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    scl_drv = 1'b1;
    sda_drv = 1'b1;
    reset   = 1'b0;
    repeat (5) @(negedge clk);
    check("reset wr_stb", 32'(wr_stb), 32'd0);
    check("reset wr_addr", 32'(wr_addr), 32'd0);
    check("reset wr_data", 32'(wr_data), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset sda released", 32'(sda), 32'd1);
    reset = 1'b1;
    repeat (10) @(negedge clk);

    // Basic write: 0x98, sub 0x05, 0xA5, 0x3C
    expect_wr(5, 8'hA5);
    expect_wr(6, 8'h3C);
    i2c_start();
    send_byte("t1 dev ack", 8'h98, 1'b0);
    check("t1 busy addressed", 32'(busy), 32'd1);
    send_byte("t1 sub ack", 8'h05, 1'b0);
    send_byte("t1 d0 ack", 8'hA5, 1'b0);
    send_byte("t1 d1 ack", 8'h3C, 1'b0);
    i2c_stop();
    #(Q);
    check("t1 busy after stop", 32'(busy), 32'd0);

    // Preload reg2/reg3 for the read test
    expect_wr(2, 8'h5A);
    expect_wr(3, 8'hC3);
    i2c_start();
    send_byte("pre dev ack", 8'h98, 1'b0);
    send_byte("pre sub ack", 8'h02, 1'b0);
    send_byte("pre d0 ack", 8'h5A, 1'b0);
    send_byte("pre d1 ack", 8'hC3, 1'b0);
    i2c_stop();
    #(Q);

    // Sub 0x02, repeated START, read two bytes ACK then NACK
    i2c_start();
    send_byte("t2 dev w ack", 8'h98, 1'b0);
    send_byte("t2 sub ack", 8'h02, 1'b0);
    i2c_start();
    send_byte("t2 dev r ack", 8'h99, 1'b0);
    check("t2 busy across rstart", 32'(busy), 32'd1);
    recv_byte("t2 rd reg2", 8'h5A, 1'b0);
    recv_byte("t2 rd reg3", 8'hC3, 1'b1);
    check("t2 sda released after nack", 32'(sda), 32'd1);
    i2c_stop();
    #(Q);

    // Wrong address: no ACK, no strobe, not busy
    i2c_start();
    send_byte("t3 wrong addr nack", 8'h90, 1'b1);
    check("t3 busy stays low", 32'(busy), 32'd0);
    i2c_stop();
    #(Q);

    // Pointer wrap 63 -> 0
    expect_wr(63, 8'h11);
    expect_wr(0, 8'h22);
    i2c_start();
    send_byte("t4 dev ack", 8'h98, 1'b0);
    send_byte("t4 sub ack", 8'h3F, 1'b0);
    send_byte("t4 d0 ack", 8'h11, 1'b0);
    send_byte("t4 d1 ack", 8'h22, 1'b0);
    i2c_stop();
    #(Q);

    // STOP after four data bits discards the partial byte
    i2c_start();
    send_byte("t6 dev ack", 8'h98, 1'b0);
    send_byte("t6 sub ack", 8'h10, 1'b0);
    put_bit(1'b1);
    put_bit(1'b0);
    put_bit(1'b1);
    put_bit(1'b0);
    i2c_stop();
    #(Q);
    check("t6 busy after partial stop", 32'(busy), 32'd0);
    expect_wr(16, 8'h77);
    i2c_start();
    send_byte("t6b dev ack", 8'h98, 1'b0);
    send_byte("t6b sub ack", 8'h10, 1'b0);
    send_byte("t6b d0 ack", 8'h77, 1'b0);
    i2c_stop();
    #(Q);
    i2c_start();
    send_byte("t6c dev w ack", 8'h98, 1'b0);
    send_byte("t6c sub ack", 8'h10, 1'b0);
    i2c_start();
    send_byte("t6c dev r ack", 8'h99, 1'b0);
    recv_byte("t6c rd reg16", 8'h77, 1'b1);
    i2c_stop();
    #(Q);

    // Reset while the responder drives a 0 bit (reg 0x3F = 0x11, MSB 0)
    i2c_start();
    send_byte("t5 dev w ack", 8'h98, 1'b0);
    send_byte("t5 sub ack", 8'h3F, 1'b0);
    i2c_start();
    send_byte("t5 dev r ack", 8'h99, 1'b0);
    check("t5 rd msb driven low", 32'(sda), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("t5 sda released by reset", 32'(sda), 32'd1);
    check("t5 busy cleared by reset", 32'(busy), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    i2c_stop();
    #(Q);
    i2c_start();
    send_byte("t5b dev w ack", 8'h98, 1'b0);
    send_byte("t5b sub ack", 8'h00, 1'b0);
    i2c_start();
    send_byte("t5b dev r ack", 8'h99, 1'b0);
    recv_byte("t5b rd reg0 cleared", 8'h00, 1'b1);
    i2c_stop();
    #(Q);

    repeat (20) @(negedge clk);
    check("wr queue drained", 32'(wr_exp_addr_q.size()), 32'd0);
    check("bus queue drained", 32'(bus_exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_reg_responder.md
I2C_REG_RESPONDER -- requirements
Module: i2c_reg_responder

Interface
REQ-001 Parameter DEV_ADDR, default 7'h4C, 7-bit I2C device address this block answers to.
REQ-002 Parameter REG_AW, default 6, register-file address width; depth is 2**REG_AW bytes.
REQ-003 Port clk  input  1  system clock, 100 MHz; all logic rising-edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset.
REQ-005 Port scl  input  1  I2C clock from the bus master; no clock stretching.
REQ-006 Port sda  inout  1  I2C data, open-drain: driven 1'b0 or 1'bz only, never 1'b1.
REQ-007 Port wr_stb  output  1  one-clk pulse per data byte written into the register file.
REQ-008 Port wr_addr  output  REG_AW  register index of the byte flagged by wr_stb.
REQ-009 Port wr_data  output  8  byte value flagged by wr_stb.
REQ-010 Port busy  output  1  high from detected START to detected STOP while addressed.

Function
REQ-011 scl and sda (read back from the pad) SHALL pass through 2-FF synchronizers; edges are detected on the synchronized copies.
REQ-012 START = sda falling while scl high; STOP = sda rising while scl high; both are recognised in any state.
REQ-013 Bits SHALL be sampled on synchronized scl rising edge, MSB first.
REQ-014 sda SHALL be driven or released on the clk after a synchronized scl falling edge, so drive changes within 4 clk of the pad scl fall.
REQ-015 FSM states: IDLE, DEV_ADDR, DEV_ACK, SUB_ADDR, SUB_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK.
REQ-016 IDLE -> DEV_ADDR on START; DEV_ADDR shifts 8 bits (7 address + R/W).
REQ-017 Address match -> DEV_ACK (drive sda low for one scl period); mismatch -> IDLE with sda released until next START.
REQ-018 After DEV_ACK: W=0 -> SUB_ADDR; R=1 -> RD_DATA loading the byte at the current pointer.
REQ-019 SUB_ADDR byte is ACKed; its low REG_AW bits load the pointer, upper bits ignored; then WR_DATA.
REQ-020 Each WR_DATA byte is ACKed, written to regfile[pointer], pulses wr_stb with wr_addr/wr_data on the 8th-bit sample clk + 1, then increments the pointer.
REQ-021 RD_DATA drives sda low for 0 bits and releases it for 1 bits; RD_ACK samples master ACK: low -> increment pointer, load next byte, RD_DATA; high (NACK) -> IDLE, sda released.
REQ-022 Pointer increments modulo 2**REG_AW (wraps from max to 0).
REQ-023 Repeated START in any state SHALL go to DEV_ADDR with the pointer preserved (write-subaddress-then-read).
REQ-024 STOP in any state SHALL go to IDLE, release sda, and drop busy; a partial byte is discarded with no wr_stb.
REQ-025 Register contents and pointer persist across transactions; only reset clears them.

Reset
REQ-026 Reset low SHALL asynchronously force: state IDLE, sda released (z), wr_stb 0, wr_addr 0, wr_data 0, busy 0, pointer 0, all registers 8'h00, synchronizers to 1.
REQ-027 Reset asserted mid-transaction SHALL release sda immediately; after release the block ignores the bus until the next START.

Structure
REQ-028 State encoding and a default device-address constant SHALL live in the shared package i2c_pkg, also usable by the vga_setup master bench.
REQ-029 One sub-module, i2c_bus_sync, SHALL hold both synchronizers and emit scl_rise, scl_fall, start_det, stop_det pulses.

Verification
REQ-030 Bench with pullups on scl/sda, 100 kHz master: write 0x98 (addr 0x4C W), sub 0x05, data 0xA5, 0x3C, STOP -> three ACKs then ACK, wr_stb twice with (5,0xA5),(6,0x3C).
REQ-031 Write sub 0x02, repeated START, 0x99 read two bytes ACK then NACK, STOP -> bytes reg[2], reg[3] on sda, sda released after NACK.
REQ-032 Address 0x90 (0x48 W) -> no ACK (sda high on 9th clock), no wr_stb, busy stays 0.
REQ-033 Write sub 0x3F, data 0x11, 0x22 -> wr_addr 63 then 0, pointer wraps.
REQ-034 Reset pulsed low during RD_DATA while driving 0 -> sda goes z within 1 clk, read-back of reg 0 after reset returns 0x00.
REQ-035 STOP after 4 bits of a data byte -> no wr_stb, state IDLE, next transaction completes normally.
